// File: rtl/switch_pkg.sv
// Shared constants and types for the slide-switch conditioning slice.
// Imported by switch_debounce_bit and switch_debouncer.
package switch_pkg;

    localparam int SWITCH_WIDTH   = 8;
    localparam int SAMPLE_DIV_1MS = 100000;

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_SETTLING = 1'b1
    } deb_state_e;

    // Counter width for a 0..n-1 range; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch bit: two-flop synchroniser, qualification counter and
// STABLE/SETTLING debounce FSM advanced only on sample ticks.
module switch_debounce_bit
    import switch_pkg::*;
#(
    parameter int STABLE_SAMPLES = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic tick_i,
    input  logic raw_i,
    output logic debounced_o,
    output logic flip_o
);

    localparam int CNT_W = $clog2(STABLE_SAMPLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    deb_state_e       state_q;
    deb_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             deb_q;
    logic             deb_d;
    logic             flip;
    logic             differs;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    assign differs = (sync2_q != deb_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        deb_d   = deb_q;
        flip    = 1'b0;
        if (tick_i) begin
            unique case (state_q)
                ST_STABLE: begin
                    if (differs) begin
                        if (STABLE_SAMPLES == 1) begin
                            deb_d = ~deb_q;
                            flip  = 1'b1;
                            cnt_d = '0;
                        end else begin
                            cnt_d   = CNT_ONE;
                            state_d = ST_SETTLING;
                        end
                    end
                end
                ST_SETTLING: begin
                    if (!differs) begin
                        // Returned to the held level: start over.
                        cnt_d   = '0;
                        state_d = ST_STABLE;
                    end else if (cnt_q == CNT_LAST) begin
                        deb_d   = ~deb_q;
                        flip    = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_STABLE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            deb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            deb_q   <= deb_d;
        end
    end

    assign debounced_o = deb_q;
    assign flip_o      = flip;

endmodule

// File: rtl/switch_debouncer.sv
// Switch conditioning for the 0x80 peripheral: shared sample divider,
// per-bit debouncers, change strobe/mask and IRQ (SWITCH_DEBOUNCER_IRQ_EN).
module switch_debouncer
    import switch_pkg::*;
#(
    parameter int WIDTH          = SWITCH_WIDTH,
    parameter int SAMPLE_DIV     = SAMPLE_DIV_1MS,
    parameter int STABLE_SAMPLES = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] SWITCH_IN,
    output logic [WIDTH-1:0] SWITCH_VALUE,
    output logic             CHANGE_STROBE,
    output logic [WIDTH-1:0] CHANGE_MASK,
    output logic             IRQ,
    input  logic             IRQ_ACK
);

    localparam int DIV_W = cnt_width(SAMPLE_DIV);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             tick;
    logic [WIDTH-1:0] flip;
    logic             strobe_q;
    logic             strobe_d;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;

    // With SAMPLE_DIV of 1 the counter sits at 0 and ticks every cycle.
    assign tick  = (div_q == DIV_LAST);
    assign div_d = tick ? '0 : div_q + DIV_ONE;

    always_ff @(posedge CLK) begin
        if (RST) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        switch_debounce_bit #(
            .STABLE_SAMPLES (STABLE_SAMPLES)
        ) u_bit (
            .CLK         (CLK),
            .RST         (RST),
            .tick_i      (tick),
            .raw_i       (SWITCH_IN[i]),
            .debounced_o (SWITCH_VALUE[i]),
            .flip_o      (flip[i])
        );
    end

    assign strobe_d = |flip;
    assign mask_d   = flip;

    always_ff @(posedge CLK) begin
        if (RST) begin
            strobe_q <= 1'b0;
            mask_q   <= '0;
        end else begin
            strobe_q <= strobe_d;
            mask_q   <= mask_d;
        end
    end

    assign CHANGE_STROBE = strobe_q;
    assign CHANGE_MASK   = mask_q;

`ifdef SWITCH_DEBOUNCER_IRQ_EN
    logic irq_q;
    logic irq_d;

    // A fresh change outranks an acknowledge landing on the same edge.
    always_comb begin
        irq_d = irq_q;
        if (strobe_q) begin
            irq_d = 1'b1;
        end else if (IRQ_ACK) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign IRQ = irq_q;
`else
    logic unused_irq_ack;

    assign unused_irq_ack = IRQ_ACK;
    assign IRQ            = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Randomised and directed bench for switch_debouncer against a
// sample-history reference model (SAMPLE_DIV=4, STABLE_SAMPLES=3).
module tb_switch_debouncer;

    localparam int W = 8;
    localparam int D = 4;
    localparam int S = 3;
    localparam int LAT_MAX = 2 + S * D;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [W-1:0] SWITCH_IN = '0;
    logic [W-1:0] SWITCH_VALUE;
    logic         CHANGE_STROBE;
    logic [W-1:0] CHANGE_MASK;
    logic         IRQ;
    logic         IRQ_ACK = 1'b0;

    switch_debouncer #(
        .WIDTH          (W),
        .SAMPLE_DIV     (D),
        .STABLE_SAMPLES (S)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .SWITCH_IN     (SWITCH_IN),
        .SWITCH_VALUE  (SWITCH_VALUE),
        .CHANGE_STROBE (CHANGE_STROBE),
        .CHANGE_MASK   (CHANGE_MASK),
        .IRQ           (IRQ),
        .IRQ_ACK       (IRQ_ACK)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: raw pins seen two clocks late, sampled every D-th cycle
    // since reset; a bit flips after S consecutive disagreeing samples.
    logic [W-1:0] pin_hist[$];
    int           cyc;
    int           run[W];
    logic [W-1:0] m_val;
    logic         m_strobe;
    logic [W-1:0] m_mask;
    logic         m_irq;

    int           n_strobe;
    logic [W-1:0] last_mask;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        pin_hist = {8'h00, 8'h00};
        cyc      = 0;
        for (int b = 0; b < W; b++) run[b] = 0;
        m_val    = '0;
        m_strobe = 1'b0;
        m_mask   = '0;
        m_irq    = 1'b0;
    endtask

    task automatic model_edge(input logic [W-1:0] sw, input logic ack,
                              input logic rst);
        logic [W-1:0] seen;
        logic [W-1:0] flips;
        if (rst) begin
            model_reset();
            return;
        end
        seen  = pin_hist[0];
        flips = '0;
        if (cyc % D == D - 1) begin
            for (int b = 0; b < W; b++) begin
                if (seen[b] != m_val[b]) begin
                    run[b] = run[b] + 1;
                    if (run[b] == S) begin
                        flips[b] = 1'b1;
                        run[b]   = 0;
                    end
                end else begin
                    run[b] = 0;
                end
            end
        end
`ifdef SWITCH_DEBOUNCER_IRQ_EN
        if (m_strobe) m_irq = 1'b1;
        else if (ack) m_irq = 1'b0;
`else
        m_irq = 1'b0;
        if (ack) m_irq = 1'b0;
`endif
        m_val    = m_val ^ flips;
        m_strobe = (flips != '0);
        m_mask   = flips;
        void'(pin_hist.pop_front());
        pin_hist.push_back(sw);
        cyc++;
    endtask

    task automatic step(input logic [W-1:0] sw, input logic ack,
                        input logic rst);
        @(negedge CLK);
        SWITCH_IN = sw;
        IRQ_ACK   = ack;
        RST       = rst;
        @(posedge CLK);
        model_edge(sw, ack, rst);
        #1;
        chk("value", SWITCH_VALUE, m_val);
        chk("strobe", CHANGE_STROBE, m_strobe);
        chk("mask", CHANGE_MASK, m_mask);
        chk("irq", IRQ, m_irq);
        if (CHANGE_STROBE) begin
            n_strobe++;
            last_mask = CHANGE_MASK;
        end
    endtask

    task automatic hold(input logic [W-1:0] sw, input int n);
        for (int i = 0; i < n; i++) step(sw, 1'b0, 1'b0);
    endtask

    task automatic wait_val(input logic [W-1:0] sw, input string tag);
        int n;
        n = 0;
        while (SWITCH_VALUE !== sw && n < 3 * LAT_MAX) begin
            step(sw, 1'b0, 1'b0);
            n++;
        end
        chk(tag, (n <= LAT_MAX) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        logic [W-1:0] cur;
        logic [W-1:0] drv;
        logic         ack;
        int           r;

        model_reset();
        n_strobe  = 0;
        last_mask = '0;

        for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 1'b1);
        chk("rst_value", SWITCH_VALUE, 8'h00);
        chk("rst_irq", IRQ, 0);

        hold(8'h00, 50);
        chk("idle_strobes", n_strobe, 0);
        chk("idle_value", SWITCH_VALUE, 8'h00);

        n_strobe = 0;
        wait_val(8'h05, "lat_05");
        hold(8'h05, 6);
        chk("strobes_05", n_strobe, 1);
        chk("mask_05", last_mask, 8'h05);
`ifdef SWITCH_DEBOUNCER_IRQ_EN
        chk("irq_set_05", IRQ, 1);
`else
        chk("irq_off_05", IRQ, 0);
`endif
        step(8'h05, 1'b1, 1'b0);
        chk("irq_acked", IRQ, 0);
        hold(8'h05, 4);

        n_strobe = 0;
        for (int k = 0; k < 5; k++) begin
            hold(8'h0D, D);
            hold(8'h05, D);
        end
        hold(8'h05, 8);
        chk("glitch_value", SWITCH_VALUE, 8'h05);
        chk("glitch_strobes", n_strobe, 0);

        n_strobe = 0;
        wait_val(8'h0A, "lat_0a");
        hold(8'h0A, 6);
        chk("strobes_0a", n_strobe, 1);
        chk("mask_0a", last_mask, 8'h0F);

        n_strobe = 0;
        for (int i = 0; i < 3 * LAT_MAX; i++) step(8'h03, m_strobe, 1'b0);
        chk("coinc_value", SWITCH_VALUE, 8'h03);
        chk("coinc_mask", last_mask, 8'h09);
`ifdef SWITCH_DEBOUNCER_IRQ_EN
        chk("irq_set_wins", IRQ, 1);
`else
        chk("irq_off_coinc", IRQ, 0);
`endif
        step(8'h03, 1'b1, 1'b0);
        chk("irq_second_ack", IRQ, 0);

        cur = 8'h03;
        for (int i = 0; i < 1200; i++) begin
            r   = $urandom_range(0, 23);
            drv = cur;
            if (r == 0) begin
                cur = W'($urandom);
                drv = cur;
            end else if (r < 4) begin
                drv = cur ^ W'(1 << $urandom_range(0, W - 1));
            end
            ack = ($urandom_range(0, 7) == 0);
            step(drv, ack, 1'b0);
        end
        hold(cur, 3 * LAT_MAX);
        chk("rand_settled", SWITCH_VALUE, cur);

        step(8'h00, 1'b1, 1'b0);
        hold(8'h00, 3 * LAT_MAX);
        step(8'h00, 1'b1, 1'b0);
        hold(8'hFF, 6);
        chk("mid_settle_value", SWITCH_VALUE, 8'h00);
        step(8'hFF, 1'b0, 1'b1);
        chk("rst_mid_value", SWITCH_VALUE, 8'h00);
        chk("rst_mid_irq", IRQ, 0);
        n_strobe = 0;
        wait_val(8'hFF, "lat_ff");
        hold(8'hFF, 6);
        chk("strobes_ff", n_strobe, 1);
        chk("mask_ff", last_mask, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
